// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus: requester handshakes, responses and the shared memory port.
// The slave modport is the arbiter side; master is the requesters plus memory.
interface dmem_arbiter_if;
    localparam int unsigned W = 32;

    logic         req0_valid;
    logic         req0_rw;
    logic [W-1:0] req0_addr;
    logic [W-1:0] req0_wdata;
    logic         req0_ready;
    logic         resp0_valid;
    logic [W-1:0] resp0_rdata;

    logic         req1_valid;
    logic         req1_rw;
    logic [W-1:0] req1_addr;
    logic [W-1:0] req1_wdata;
    logic         req1_ready;
    logic         resp1_valid;
    logic [W-1:0] resp1_rdata;

    logic         mem_r_w;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_data;
    logic [W-1:0] mem_out;

    modport slave (
        input  req0_valid, req0_rw, req0_addr, req0_wdata,
        input  req1_valid, req1_rw, req1_addr, req1_wdata,
        input  mem_out,
        output req0_ready, resp0_valid, resp0_rdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output mem_r_w, mem_addr, mem_data
    );

    modport master (
        output req0_valid, req0_rw, req0_addr, req0_wdata,
        output req1_valid, req1_rw, req1_addr, req1_wdata,
        output mem_out,
        input  req0_ready, resp0_valid, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  mem_r_w, mem_addr, mem_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter granting two requesters one at a time onto a single data-memory port.
// Optional macro DMEM_ARB_STALL_CNT_EN adds a saturating stall_cnt[15:0] output.
module dmem_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SC_W  = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_id;
    logic               r_rw;
    logic [W-1:0]       r_addr;
    logic [W-1:0]       r_wdata;
    logic [W-1:0]       r_rdata0;
    logic [W-1:0]       r_rdata1;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_grant;
    logic               w_accept;
    logic               w_acc_done;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_resp0;
    logic               w_resp1;
    logic               w_mem_r_w;

    // Tie goes to the requester not served last; otherwise the only valid one wins.
    assign w_grant    = (bus.req0_valid && bus.req1_valid) ? ~r_last : ~bus.req0_valid;
    assign w_acc_done = r_rw || (r_cnt == CNT_W'(RD_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_resp0     = 1'b0;
        w_resp1     = 1'b0;
        w_mem_r_w   = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst_n so ready drops the instant reset asserts.
                if ((bus.req0_valid || bus.req1_valid) && rst_n) begin
                    w_accept    = 1'b1;
                    w_ready0    = ~w_grant;
                    w_ready1    = w_grant;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_r_w = r_rw;
                if (w_acc_done) w_state_nxt = RESP;
            end
            RESP: begin
                w_resp0     = ~r_id;
                w_resp1     = r_id;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, access timing and read-data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_rw    <= w_grant ? bus.req1_rw    : bus.req0_rw;
            r_addr  <= w_grant ? bus.req1_addr  : bus.req0_addr;
            r_wdata <= w_grant ? bus.req1_wdata : bus.req0_wdata;
            r_cnt   <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_acc_done && !r_rw) begin
                if (r_id) r_rdata1 <= bus.mem_out;
                else      r_rdata0 <= bus.mem_out;
            end
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.resp0_valid = w_resp0;
    assign bus.resp1_valid = w_resp1;
    assign bus.resp0_rdata = r_rdata0;
    assign bus.resp1_rdata = r_rdata1;
    assign bus.mem_r_w     = w_mem_r_w;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_data    = r_wdata;

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [SC_W-1:0] r_stall_cnt;
    logic            w_stall;

    assign w_stall = (bus.req0_valid && !w_ready0) || (bus.req1_valid && !w_ready1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + SC_W'(1);
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table-driven transactions with a response scoreboard plus
// hand-written reset-abort, RD_LAT=3 and (when DMEM_ARB_STALL_CNT_EN) stall-counter sequences.
module tb_dmem_arbiter;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned RD_LAT3 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();
    dmem_arbiter_if bus3 ();

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt3;
`endif

    dmem_arbiter #(.RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef DMEM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    dmem_arbiter #(.RD_LAT(RD_LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
`ifdef DMEM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    // Memory model behind the RD_LAT=1 instance, and the bench's golden copy.
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] gmem [logic [31:0]];

    always @(posedge clk) begin
        bus.mem_out <= bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr] : dflt(bus.mem_addr);
        if (bus.mem_r_w) bmem[bus.mem_addr] = bus.mem_data;
    end

    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= dflt(bus3.mem_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.mem_out = p3[2];

    function automatic logic [31:0] gread(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v0, v1, rw0, rw1;
        logic [31:0] a0, a1, d0, d1;
        logic        exp_grant;
        int          lat;
    } vec_t;

    typedef struct {
        logic        port;
        logic        rw;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hold0 = '0;
    logic [31:0] hold1 = '0;

    // One accept from IDLE, then cycle-by-cycle checks up to and including the response.
    task automatic run_vec(input vec_t v, input string tag);
        logic        g, erw;
        logic [31:0] ea, ed;
        exp_t        e, got;
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req0_rw = v.rw0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
        bus.req1_valid = v.v1; bus.req1_rw = v.rw1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
        #1;
        chk({tag, " ready0"}, 32'(bus.req0_ready), 32'(!v.exp_grant));
        chk({tag, " ready1"}, 32'(bus.req1_ready), 32'(v.exp_grant));
        g   = v.exp_grant;
        erw = g ? v.rw1 : v.rw0;
        ea  = g ? v.a1 : v.a0;
        ed  = g ? v.d1 : v.d0;
        e.port = g; e.rw = erw; e.lat = v.lat;
        if (erw) begin
            gmem[ea] = ed;
            e.rdata  = g ? hold1 : hold0;
        end else begin
            e.rdata  = gread(ea);
        end
        sb.push_back(e);
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            if (g) bus.req1_valid = 1'b0;
            else   bus.req0_valid = 1'b0;
            #1;
            chk({tag, " busy ready0"}, 32'(bus.req0_ready), 32'(0));
            chk({tag, " busy ready1"}, 32'(bus.req1_ready), 32'(0));
            chk({tag, " mem_r_w"},     32'(bus.mem_r_w),    32'(erw && c == 1));
            chk({tag, " mem_addr"},    bus.mem_addr, ea);
            chk({tag, " mem_data"},    bus.mem_data, ed);
            chk({tag, " resp0_valid"}, 32'(bus.resp0_valid), 32'(c == v.lat && !g));
            chk({tag, " resp1_valid"}, 32'(bus.resp1_valid), 32'(c == v.lat && g));
            if (c == v.lat) begin
                got = sb.pop_front();
                if (got.port) begin
                    chk({tag, " resp1_rdata"}, bus.resp1_rdata, got.rdata);
                    chk({tag, " resp0_rdata hold"}, bus.resp0_rdata, hold0);
                    hold1 = got.rdata;
                end else begin
                    chk({tag, " resp0_rdata"}, bus.resp0_rdata, got.rdata);
                    chk({tag, " resp1_rdata hold"}, bus.resp1_rdata, hold1);
                    hold0 = got.rdata;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready0"},  32'(bus.req0_ready),  32'(0));
        chk({tag, " ready1"},  32'(bus.req1_ready),  32'(0));
        chk({tag, " resp0"},   32'(bus.resp0_valid), 32'(0));
        chk({tag, " resp1"},   32'(bus.resp1_valid), 32'(0));
        chk({tag, " mem_r_w"}, 32'(bus.mem_r_w),     32'(0));
        chk({tag, " mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, " mem_data"}, bus.mem_data, 32'h0);
        chk({tag, " rdata0"},   bus.resp0_rdata, 32'h0);
        chk({tag, " rdata1"},   bus.resp1_rdata, 32'h0);
    endtask

    vec_t vt[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b1; bus.req0_rw = 1'b0; bus.req0_addr = 32'h10; bus.req0_wdata = '0;
        bus.req1_valid = 1'b1; bus.req1_rw = 1'b0; bus.req1_addr = 32'h24; bus.req1_wdata = '0;
        bus3.req0_valid = 1'b0; bus3.req0_rw = 1'b0; bus3.req0_addr = '0; bus3.req0_wdata = '0;
        bus3.req1_valid = 1'b0; bus3.req1_rw = 1'b0; bus3.req1_addr = '0; bus3.req1_wdata = '0;
        bmem[32'h10] = 32'hDEAD_BEEF;
        gmem[32'h10] = 32'hDEAD_BEEF;

        //        v0    v1    rw0   rw1   a0            a1            d0             d1             g     lat
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h1111_0000, 32'h0,         1'b0, 3};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_8004, 32'h0,        32'h1234_5678, 1'b1, 2};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_8004, 32'h0,        32'h2222_0000, 1'b1, 3};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0024, 32'h3333_0000, 32'h4444_0000, 1'b0, 3};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0024, 32'h3333_0000, 32'h4444_0000, 1'b1, 3};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0024, 32'h3333_0000, 32'h4444_0000, 1'b0, 3};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0024, 32'h3333_0000, 32'h4444_0000, 1'b1, 3};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_0030, 32'hAAAA_5555, 32'h5555_0000, 1'b0, 2};
        vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0030, 32'h6666_0000, 32'h7777_0000, 1'b1, 3};
        vt[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h5A5A_1234, 32'h0,         1'b0, 2};

        // Reset state, with both requesters valid to prove ready is held low.
        #1;
        chk_all_zero("reset");
        @(negedge clk); #1;
        chk_all_zero("reset2");
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));
        chk("sb empty", 32'(sb.size()), 32'(0));

        // Reset asserted mid read access: outputs clear at once and no response follows.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_rw = 1'b0; bus.req0_addr = 32'h50; bus.req0_wdata = 32'h9999_0000;
        bus.req1_valid = 1'b0;
        #1;
        chk("abort accept ready0", 32'(bus.req0_ready), 32'(1));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("abort in access addr", bus.mem_addr, 32'h50);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        hold0 = '0; hold1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("post-abort resp0", 32'(bus.resp0_valid), 32'(0));
            chk("post-abort resp1", 32'(bus.resp1_valid), 32'(0));
        end
        run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h30, 32'h0, 32'h0, 1'b0, 3}, "after-abort");
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // RD_LAT=3 instance: response in cycle 5, address held throughout.
        @(negedge clk);
        bus3.req0_valid = 1'b1; bus3.req0_addr = 32'h40; bus3.req0_rw = 1'b0;
        #1;
        chk("lat3 ready0", 32'(bus3.req0_ready), 32'(1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus3.req0_valid = 1'b0;
            #1;
            chk("lat3 mem_addr", bus3.mem_addr, 32'h40);
            chk("lat3 mem_r_w", 32'(bus3.mem_r_w), 32'(0));
            chk("lat3 resp0_valid", 32'(bus3.resp0_valid), 32'(c == 5));
            chk("lat3 resp1_valid", 32'(bus3.resp1_valid), 32'(0));
        end
        chk("lat3 rdata0", bus3.resp0_rdata, dflt(32'h40));

`ifdef DMEM_ARB_STALL_CNT_EN
        // One read each with both valid: port 1 waits cycles 0..3.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_rw = 1'b0; bus.req0_addr = 32'h10;
        bus.req1_valid = 1'b1; bus.req1_rw = 1'b0; bus.req1_addr = 32'h24;
        #1;
        chk("stall ready0", 32'(bus.req0_ready), 32'(1));
        @(negedge clk); bus.req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stall ready1", 32'(bus.req1_ready), 32'(1));
        @(negedge clk); bus.req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stall_cnt 4", 32'(stall_cnt), 32'(4));
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        repeat (70000) @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("stall_cnt sat", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: RD_LAT, default 1, data-memory read latency in cycles (legal 1..3).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an access.
REQ-005 reqN_rw  input  1  (N=0,1) 1=write, 0=read.
REQ-006 reqN_addr  input  32  (N=0,1) byte address.
REQ-007 reqN_wdata  input  32  (N=0,1) write data.
REQ-008 reqN_ready  output  1  (N=0,1) request accepted this cycle.
REQ-009 respN_valid  output  1  (N=0,1) one-cycle completion pulse.
REQ-010 respN_rdata  output  32  (N=0,1) read data, valid with respN_valid.
REQ-011 mem_r_w  output  1  memory write enable, 1=write.
REQ-012 mem_addr  output  32  memory address.
REQ-013 mem_data  output  32  memory write data.
REQ-014 mem_out  input  32  memory read data, valid RD_LAT cycles after address is sampled.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-016 In IDLE, the block SHALL grant exactly one valid requester: single valid -> that one; both valid -> the one not granted last (round-robin).
REQ-017 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; never both high.
REQ-018 On the accept edge, rw/addr/wdata and grant id SHALL be registered and the FSM SHALL enter ACCESS; last-grant SHALL update to the granted id.
REQ-019 Write: ACCESS SHALL last 1 cycle with mem_r_w=1, then RESP.
REQ-020 Read: ACCESS SHALL last RD_LAT+1 cycles with mem_r_w=0; mem_out SHALL be captured into the granted port's rdata register on the final ACCESS edge; then RESP.
REQ-021 mem_addr/mem_data SHALL be driven from the registered request and held unchanged through ACCESS and RESP and IDLE until the next accept.
REQ-022 mem_r_w SHALL be 0 in every cycle other than a write ACCESS cycle.
REQ-023 RESP SHALL last exactly 1 cycle with respN_valid=1 for the granted port only, then IDLE; no accept occurs in ACCESS or RESP.
REQ-024 Latency from accept cycle (cycle 0): write resp in cycle 2; read resp in cycle RD_LAT+2.
REQ-025 respN_rdata SHALL hold its last captured value between responses; writes SHALL NOT modify it.
REQ-026 Requester deasserting valid without ready SHALL be legal; arbiter SHALL not remember it.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, last-grant=1 (port 0 wins first tie), all ready/resp_valid/mem_r_w=0, mem_addr/mem_data/respN_rdata=0.
REQ-028 Reset during ACCESS or RESP SHALL abort the access with no response pulse; first grant after release follows REQ-016.

Configuration
REQ-029 Macro DMEM_ARB_STALL_CNT_EN: when defined, output stall_cnt[15:0] SHALL count cycles where any reqN_valid=1 with reqN_ready=0, saturating at 0xFFFF, reset to 0.
REQ-030 Without DMEM_ARB_STALL_CNT_EN, port stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 RD_LAT=1, req0 read addr 0x0000_0010, mem_out=0xDEAD_BEEF -> ready0 cycle 0, mem_r_w=0, resp0_valid cycle 3, resp0_rdata=0xDEAD_BEEF.
REQ-032 req1 write addr 0x0000_8004 data 0x1234_5678 -> mem_r_w=1 only in cycle 1 with those addr/data, resp1_valid cycle 2, resp1_rdata unchanged.
REQ-033 Both valid continuously from reset, 4 reads -> grants 0,1,0,1; never both ready; each resp on its own port.
REQ-034 rst_n pulsed low during read ACCESS -> no resp pulse, all outputs 0 immediately, next req0 served normally.
REQ-035 RD_LAT=3, req0 read -> resp0_valid cycle 5, mem_addr stable cycles 1-5.
REQ-036 DMEM_ARB_STALL_CNT_EN defined, both valid for one read each (RD_LAT=1) -> stall_cnt=4; forced 70000 stall cycles -> stall_cnt=0xFFFF.
